// File: rtl/mips16_core.sv
// mips16_core: single-cycle 16-bit MIPS-style CPU with 8 registers and 24-word
// instruction/data memories preloaded from flat buses while reset is held low.
module mips16_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_d,
    output logic [15:0] PC_out
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) PC_out <= '0;
        else PC_out <= pc_d;
endmodule

module mips16_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] init,
    input  logic [2:0]  ra_a,
    input  logic [2:0]  ra_b,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    output logic [15:0] rd_a,
    output logic [15:0] rd_b
);
    logic [15:0] internal_memory [0:7];

    // r0 is never written, so it reads 0 without a read-side mux
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < 8; i++)
                internal_memory[i] <= i == 1 ? init[15:0] : i == 2 ? init[31:16] : 16'h0;
        else if (we && wa != 3'd0)
            internal_memory[wa] <= wd;

    assign rd_a = internal_memory[ra_a];
    assign rd_b = internal_memory[ra_b];
endmodule

module mips16_mem (
    input  logic         clk,
    input  logic         rst,
    input  logic [383:0] image,
    input  logic [15:0]  addr,
    input  logic         we,
    input  logic [15:0]  wd,
    output logic [15:0]  rd
);
    logic [15:0] internal_mem [0:23];
    logic        hit;

    assign hit = addr < 16'd24;

    // word 0 sits in the MSBs of the image bus
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < 24; i++)
                internal_mem[i] <= image[383 - 16*i -: 16];
        else if (we && hit)
            internal_mem[addr[4:0]] <= wd;

    assign rd = hit ? internal_mem[addr[4:0]] : 16'h0;
endmodule

module mips16_core (
    input  logic         clk,
    input  logic         rst,
    input  logic [383:0] in_instr,
    input  logic [383:0] in_data,
    input  logic [31:0]  in_val,
    output logic [15:0]  current_instr
);
    logic [15:0] pc, pc_d, instr, imm, a, b, r_res, ld, daddr, wd, pc_inc;
    logic [3:0]  op;
    logic [2:0]  funct;
    logic        we, take;

    mips16_pc PC (.clk(clk), .rst(rst), .pc_d(pc_d), .PC_out(pc));

    mips16_mem instr_memory (
        .clk(clk), .rst(rst), .image(in_instr), .addr(pc),
        .we(1'b0), .wd(16'h0), .rd(instr)
    );

    mips16_regfile register_file (
        .clk(clk), .rst(rst), .init(in_val), .ra_a(instr[11:9]), .ra_b(instr[8:6]),
        .we(we), .wa(op == 4'h0 ? instr[5:3] : instr[8:6]), .wd(wd), .rd_a(a), .rd_b(b)
    );

    mips16_mem data_memory (
        .clk(clk), .rst(rst), .image(in_data), .addr(daddr),
        .we(op == 4'hB), .wd(b), .rd(ld)
    );

    assign current_instr = instr;
    assign op     = instr[15:12];
    assign funct  = instr[2:0];
    assign imm    = {{10{instr[5]}}, instr[5:0]};
    assign daddr  = a + imm;
    assign pc_inc = pc + 16'd1;

    always_comb begin
        r_res = funct == 3'd0 ? a + b :
                funct == 3'd1 ? a - b :
                funct == 3'd2 ? a & b :
                funct == 3'd3 ? a | b :
                funct == 3'd4 ? {15'h0, $signed(a) < $signed(b)} : a ^ b;
        wd    = op == 4'h0 ? r_res : op == 4'h9 ? ld : daddr;
        we    = (op == 4'h0 && funct < 3'd6) || op == 4'h8 || op == 4'h9;
        take  = (op == 4'hC && a == b) || (op == 4'hD && a != b);
        pc_d  = op == 4'h4 ? {4'h0, instr[11:0]} : take ? pc_inc + imm : pc_inc;
    end
endmodule

// File: tb/tb_mips16_core.sv
// tb_mips16_core: directed-vector bench for mips16_core with hand-computed
// expectations on PC, registers, data memory and current_instr.
module tb_mips16_core;
    logic         clk = 0;
    logic         rst = 0;
    logic [383:0] in_instr = '0;
    logic [383:0] in_data = '0;
    logic [31:0]  in_val = '0;
    logic [15:0]  current_instr;
    logic [15:0]  im [0:23];
    logic [15:0]  dm [0:23];
    int vectors = 0;
    int miscompares = 0;

    mips16_core dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_data(in_data),
        .in_val(in_val), .current_instr(current_instr)
    );

    always #5 clk = ~clk;

    task automatic clear_images();
        for (int i = 0; i < 24; i++) begin
            im[i] = 16'h0;
            dm[i] = 16'h0;
        end
    endtask

    // hold reset over a clock edge so the images are captured, release on a negedge
    task automatic load(input logic [31:0] val);
        @(negedge clk);
        rst = 0;
        in_val = val;
        for (int i = 0; i < 24; i++) begin
            in_instr[383 - 16*i -: 16] = im[i];
            in_data[383 - 16*i -: 16] = dm[i];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clear_images();
        im[0] = 16'h9041;
        dm[3] = 16'h0031;
        load(32'h0002_0005);
        vectors++;
        if (dut.PC.PC_out !== 16'd0) begin miscompares++; $display("FAIL reset_pc got %h want 0000", dut.PC.PC_out); end
        vectors++;
        if (dut.register_file.internal_memory[1] !== 16'd5) begin miscompares++; $display("FAIL reset_r1 got %h want 0005", dut.register_file.internal_memory[1]); end
        vectors++;
        if (dut.register_file.internal_memory[2] !== 16'd2) begin miscompares++; $display("FAIL reset_r2 got %h want 0002", dut.register_file.internal_memory[2]); end
        for (int r = 3; r < 8; r++) begin
            vectors++;
            if (dut.register_file.internal_memory[r] !== 16'd0) begin miscompares++; $display("FAIL reset_r%0d got %h want 0000", r, dut.register_file.internal_memory[r]); end
        end
        vectors++;
        if (dut.data_memory.internal_mem[3] !== 16'h0031) begin miscompares++; $display("FAIL reset_dmem3 got %h want 0031", dut.data_memory.internal_mem[3]); end
        vectors++;
        if (current_instr !== 16'h9041) begin miscompares++; $display("FAIL reset_instr got %h want 9041", current_instr); end
    endtask

    task automatic test_back_to_back();
        clear_images();
        im[0] = 16'h9041;
        im[1] = 16'h0250;
        im[2] = 16'hB083;
        dm[1] = 16'h0023;
        load(32'h0002_0005);
        rst = 1;
        step(1);
        vectors++;
        if (dut.register_file.internal_memory[1] !== 16'd35) begin miscompares++; $display("FAIL lw_r1 got %h want 0023", dut.register_file.internal_memory[1]); end
        vectors++;
        if (dut.PC.PC_out !== 16'd1) begin miscompares++; $display("FAIL lw_pc got %h want 0001", dut.PC.PC_out); end
        vectors++;
        if (current_instr !== 16'h0250) begin miscompares++; $display("FAIL lw_instr got %h want 0250", current_instr); end
        step(2);
        vectors++;
        if (dut.register_file.internal_memory[2] !== 16'd70) begin miscompares++; $display("FAIL add_r2 got %h want 0046", dut.register_file.internal_memory[2]); end
        vectors++;
        if (dut.data_memory.internal_mem[3] !== 16'd70) begin miscompares++; $display("FAIL sw_dmem3 got %h want 0046", dut.data_memory.internal_mem[3]); end
        vectors++;
        if (dut.PC.PC_out !== 16'd3) begin miscompares++; $display("FAIL sw_pc got %h want 0003", dut.PC.PC_out); end
    endtask

    task automatic test_alu();
        logic [15:0] exp [3:7];
        clear_images();
        im[0] = 16'h0298; im[1] = 16'h02A1; im[2] = 16'h02AA; im[3] = 16'h02B3;
        im[4] = 16'h047C; im[5] = 16'h029D; im[6] = 16'h02A6;
        exp[3] = 16'hFFFB; exp[4] = 16'h0007; exp[5] = 16'h0004; exp[6] = 16'hFFFF; exp[7] = 16'h0001;
        load(32'hFFFE_0005);
        rst = 1;
        step(1);
        vectors++;
        if (dut.register_file.internal_memory[3] !== 16'h0003) begin miscompares++; $display("FAIL alu_add got %h want 0003", dut.register_file.internal_memory[3]); end
        step(6);
        for (int r = 3; r < 8; r++) begin
            vectors++;
            if (dut.register_file.internal_memory[r] !== exp[r]) begin miscompares++; $display("FAIL alu_r%0d got %h want %h", r, dut.register_file.internal_memory[r], exp[r]); end
        end
    endtask

    task automatic test_branch();
        logic [15:0] br [0:3];
        logic [15:0] tgt [0:3];
        br[0] = 16'hC002; tgt[0] = 16'd6;
        br[1] = 16'hD002; tgt[1] = 16'd4;
        br[2] = 16'hD042; tgt[2] = 16'd6;
        br[3] = 16'hC03C; tgt[3] = 16'd0;
        for (int k = 0; k < 4; k++) begin
            clear_images();
            im[3] = br[k];
            load(32'h0002_0005);
            rst = 1;
            step(4);
            vectors++;
            if (dut.PC.PC_out !== tgt[k]) begin miscompares++; $display("FAIL branch_%h got pc %h want %h", br[k], dut.PC.PC_out, tgt[k]); end
        end
    endtask

    task automatic test_jump_oob();
        clear_images();
        im[0] = 16'h4005;
        im[5] = 16'h401E;
        load(32'h0002_0005);
        rst = 1;
        step(1);
        vectors++;
        if (dut.PC.PC_out !== 16'd5) begin miscompares++; $display("FAIL jump_pc got %h want 0005", dut.PC.PC_out); end
        step(1);
        vectors++;
        if (current_instr !== 16'h0000) begin miscompares++; $display("FAIL oob_fetch got %h want 0000", current_instr); end
        step(2);
        vectors++;
        if (dut.PC.PC_out !== 16'd32) begin miscompares++; $display("FAIL oob_pc got %h want 0020", dut.PC.PC_out); end
        vectors++;
        if (dut.register_file.internal_memory[1] !== 16'd5) begin miscompares++; $display("FAIL oob_r1 got %h want 0005", dut.register_file.internal_memory[1]); end
        clear_images();
        im[0] = 16'hB05E;
        im[1] = 16'h909E;
        im[2] = 16'hB057;
        for (int i = 0; i < 24; i++) dm[i] = 16'h0100 + 16'(i);
        load(32'h0002_1234);
        rst = 1;
        step(2);
        vectors++;
        if (dut.register_file.internal_memory[2] !== 16'd0) begin miscompares++; $display("FAIL oob_lw got %h want 0000", dut.register_file.internal_memory[2]); end
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if (dut.data_memory.internal_mem[i] !== dm[i]) begin miscompares++; $display("FAIL oob_sw_dmem%0d got %h want %h", i, dut.data_memory.internal_mem[i], dm[i]); end
        end
        step(1);
        vectors++;
        if (dut.data_memory.internal_mem[23] !== 16'h1234) begin miscompares++; $display("FAIL sw_last_word got %h want 1234", dut.data_memory.internal_mem[23]); end
    endtask

    task automatic test_r0_async();
        clear_images();
        im[0] = 16'h8007;
        im[1] = 16'h8047;
        im[2] = 16'hB044;
        dm[4] = 16'h00AA;
        load(32'h0002_0005);
        rst = 1;
        step(1);
        vectors++;
        if (dut.register_file.internal_memory[0] !== 16'd0) begin miscompares++; $display("FAIL r0_write got %h want 0000", dut.register_file.internal_memory[0]); end
        step(2);
        vectors++;
        if (dut.data_memory.internal_mem[4] !== 16'd7) begin miscompares++; $display("FAIL addi_sw got %h want 0007", dut.data_memory.internal_mem[4]); end
        #2 rst = 0;
        #1;
        vectors++;
        if (dut.PC.PC_out !== 16'd0) begin miscompares++; $display("FAIL async_pc got %h want 0000", dut.PC.PC_out); end
        vectors++;
        if (dut.register_file.internal_memory[1] !== 16'd5) begin miscompares++; $display("FAIL async_r1 got %h want 0005", dut.register_file.internal_memory[1]); end
        vectors++;
        if (dut.data_memory.internal_mem[4] !== 16'h00AA) begin miscompares++; $display("FAIL async_dmem4 got %h want 00aa", dut.data_memory.internal_mem[4]); end
        vectors++;
        if (current_instr !== 16'h8007) begin miscompares++; $display("FAIL async_instr got %h want 8007", current_instr); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alu();
        test_branch();
        test_jump_oob();
        test_r0_async();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
